nx_fifo_rd_prefetch: RTL and testbench

Read-side prefetch stage that sits directly downstream of an `nx_fifo` instance. It turns the FIFO's `empty`/`ren`/`rdata` pop interface into a registered valid/ready stream for the consumer. It holds up to two words in an internal skid buffer, which gives full throughput without a combinational path from `out_ready` to `fifo_ren`. It also tracks FIFO underflow as a sticky error.

---
 rtl/nx_fifo_pf_pkg.sv | 6 +
 rtl/nx_fifo_pf_buf.sv | 43 ++++
 rtl/nx_fifo_rd_prefetch.sv | 60 ++++++
 tb/tb_nx_fifo_rd_prefetch.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/nx_fifo_pf_pkg.sv
// Shared constants and types for the nx_fifo read-side prefetch stage.
package nx_fifo_pf_pkg;
  localparam int PF_DEPTH    = 2;
  localparam int STALL_CNT_W = 16;
  typedef logic [1:0] pf_cnt_t;
endpackage

// File: rtl/nx_fifo_pf_buf.sv
// Two-entry skid buffer: register file plus head/tail pointers and a word count.
module nx_fifo_pf_buf
  import nx_fifo_pf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output pf_cnt_t          count
);
  logic [WIDTH-1:0] mem [PF_DEPTH];
  logic             head, tail;

  // Data storage is deliberately left unreset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign rdata = valid ? mem[head] : '0;
endmodule

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetch: converts nx_fifo empty/ren/rdata into a registered valid/ready stream.
// Optional stall statistics counter enabled by defining NX_FIFO_PREFETCH_STATS_EN.
module nx_fifo_rd_prefetch
  import nx_fifo_pf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_underflow,
  output logic             fifo_ren,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic             err_underflow
`ifdef NX_FIFO_PREFETCH_STATS_EN
  ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
  pf_cnt_t count;
  logic    pop;

  // Pop decision uses only the registered count, so out_ready never reaches fifo_ren.
  assign fifo_ren = !rst && !fifo_empty && (count != pf_cnt_t'(PF_DEPTH)) && !clear;
  assign pop      = out_valid && out_ready && !clear;

  nx_fifo_pf_buf #(.WIDTH(WIDTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fifo_ren),
    .wdata (fifo_rdata),
    .pop   (pop),
    .valid (out_valid),
    .rdata (out_data),
    .count (count)
  );

  assign occupancy = count;

  // An underflow coinciding with clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)                 err_underflow <= 1'b0;
    else if (fifo_underflow) err_underflow <= 1'b1;
    else if (clear)          err_underflow <= 1'b0;
  end

`ifdef NX_FIFO_PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clear)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_nx_fifo_rd_prefetch.sv
// Self-checking bench: upstream FIFO and prefetch behaviour modelled with queues.
module tb_nx_fifo_rd_prefetch;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, fifo_empty, fifo_underflow, fifo_ren, clear;
  logic         out_valid, out_ready, err_underflow;
  logic [W-1:0] fifo_rdata, out_data;
  logic [1:0]   occupancy;
`ifdef NX_FIFO_PREFETCH_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  nx_fifo_rd_prefetch #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_underflow (fifo_underflow),
    .fifo_ren       (fifo_ren),
    .clear          (clear),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .occupancy      (occupancy),
    .err_underflow  (err_underflow)
`ifdef NX_FIFO_PREFETCH_STATS_EN
    ,.stall_cnt     (stall_cnt)
`endif
  );

  logic [W-1:0] up_q[$];   // upstream FIFO contents
  logic [W-1:0] buf_q[$];  // words held by the prefetch stage
  bit           m_err;
  int           m_stall;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive_up();
    fifo_empty = (up_q.size() == 0);
    fifo_rdata = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  // One cycle: apply inputs, check outputs against the model, advance model at the edge.
  task automatic step(input bit wen, input logic [W-1:0] wd, input bit rdy,
                      input bit clr, input bit und, input bit rs);
    bit exp_ren, exp_vld;
    rst = rs; clear = clr; out_ready = rdy; fifo_underflow = und;
    drive_up();
    #1;
    exp_ren = !rs && up_q.size() != 0 && buf_q.size() != 2 && !clr;
    exp_vld = buf_q.size() != 0;
    chk("fifo_ren", W'(fifo_ren), W'(exp_ren));
    chk("out_valid", W'(out_valid), W'(exp_vld));
    chk("out_data", out_data, exp_vld ? buf_q[0] : '0);
    chk("occupancy", W'(occupancy), W'(buf_q.size()));
    chk("err_underflow", W'(err_underflow), W'(m_err));
`ifdef NX_FIFO_PREFETCH_STATS_EN
    chk("stall_cnt", W'(stall_cnt), W'(m_stall));
`endif
    @(posedge clk);
    if (rs) begin
      buf_q.delete(); m_err = 0; m_stall = 0;
    end else if (clr) begin
      buf_q.delete(); m_err = und; m_stall = 0;
    end else begin
      if (exp_vld && !rdy && m_stall != 16'hFFFF) m_stall++;
      if (exp_vld && rdy) void'(buf_q.pop_front());
      if (exp_ren) buf_q.push_back(up_q[0]);
      if (und) m_err = 1;
    end
    if (exp_ren) void'(up_q.pop_front());
    if (wen) up_q.push_back(wd);
    #1;
  endtask

  initial begin
    m_err = 0; m_stall = 0;
    rst = 1; clear = 0; out_ready = 0; fifo_underflow = 0;
    drive_up();
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);

    // Single word latency through an empty FIFO
    step(1, 32'hA5, 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0);

    // Preload 8 words, hold consumer off, then drain
    for (int i = 0; i < 8; i++) step(1, W'(i), 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0, 0);

    // Clear with full buffer and simultaneous handshake
    for (int i = 0; i < 4; i++) step(1, W'(32'h100 + i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);

    // Sticky underflow, clear, then clear+underflow together
    step(0, 0, 1, 0, 1, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);

    // Reset mid-stream with one word held
    step(1, 32'h200, 0, 0, 0, 0);
    step(1, 32'h201, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 1) == 1) && up_q.size() < 16, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    repeat (6) step(0, 0, 1, 0, 0, 0);

`ifdef NX_FIFO_PREFETCH_STATS_EN
    // Long stall to saturate the counter
    step(1, 32'h300, 0, 0, 0, 0);
    for (int i = 0; i < 65600; i++) step(0, 0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
